// File: rtl/micro_op_queue.sv
// Multi-issue micro-op queue between fetch/pre-decode and decode.
// Accepts up to ENQ_N micro-ops per cycle and presents the DEQ_N oldest to decode.
module micro_op_queue #(
    parameter int DEPTH     = 16,
    parameter int ENQ_N     = 4,
    parameter int DEQ_N     = 2,
    parameter int ENTRY_W   = 128,
    parameter int AF_THRESH = 12,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1,
    localparam int EW = $clog2(ENQ_N + 1),
    localparam int DW = $clog2(DEQ_N + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EW-1:0]            enq_count,
    input  logic [ENQ_N*ENTRY_W-1:0] enq_data,
    output logic                     enq_ready,
    output logic [DEQ_N*ENTRY_W-1:0] deq_data,
    output logic [DW-1:0]            deq_avail,
    input  logic [DW-1:0]            deq_count,
    input  logic                     flush,
    output logic [CW-1:0]            occupancy,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ENQ_N_C = CW'(ENQ_N);
    localparam logic [CW-1:0] DEQ_N_C = CW'(DEQ_N);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head_q;
    logic [PW-1:0]      tail_q;
    logic [CW-1:0]      occupancy_q;

    logic               enq_accept;
    logic [DW-1:0]      eff_pop;

    // Readiness looks only at current occupancy so a same-cycle pop never
    // lengthens the path from decode back into fetch.
    assign enq_ready   = (DEPTH_C - occupancy_q) >= ENQ_N_C;
    assign deq_avail   = (occupancy_q >= DEQ_N_C) ? DW'(DEQ_N) : DW'(occupancy_q);
    assign eff_pop     = (deq_count < deq_avail) ? deq_count : deq_avail;
    assign enq_accept  = enq_ready && (enq_count != '0) && !flush && !rst;

    assign occupancy   = occupancy_q;
    assign empty       = (occupancy_q == '0);
    assign full        = (occupancy_q == DEPTH_C);
    assign almost_full = (occupancy_q >= AF_C);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q      <= '0;
            tail_q      <= '0;
            occupancy_q <= '0;
        end else begin
            head_q      <= head_q + PW'(eff_pop);
            tail_q      <= tail_q + (enq_accept ? PW'(enq_count) : PW'(0));
            occupancy_q <= occupancy_q + (enq_accept ? CW'(enq_count) : CW'(0))
                           - CW'(eff_pop);
        end
    end

    // Storage has no reset; stale slots are hidden by the deq_avail mask.
    always_ff @(posedge clk) begin
        if (enq_accept) begin
            for (int i = 0; i < ENQ_N; i++) begin
                if (EW'(i) < enq_count) begin
                    mem[tail_q + PW'(i)] <= enq_data[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    always_comb begin
        deq_data = '0;
        for (int i = 0; i < DEQ_N; i++) begin
            if (DW'(i) < deq_avail) begin
                deq_data[i*ENTRY_W +: ENTRY_W] = mem[head_q + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_micro_op_queue.sv
// Randomized and directed bench for micro_op_queue against a queue-based model.
module tb_micro_op_queue;

    localparam int DEPTH = 8;
    localparam int ENQ_N = 4;
    localparam int DEQ_N = 2;
    localparam int EWID  = 32;
    localparam int AF    = 6;

    logic                    clk;
    logic                    rst;
    logic [2:0]              enq_count;
    logic [ENQ_N*EWID-1:0]   enq_data;
    logic                    enq_ready;
    logic [DEQ_N*EWID-1:0]   deq_data;
    logic [1:0]              deq_avail;
    logic [1:0]              deq_count;
    logic                    flush;
    logic [3:0]              occupancy;
    logic                    empty;
    logic                    full;
    logic                    almost_full;

    int testsRun;
    int testsFailed;
    logic [EWID-1:0] modelQ [$];

    micro_op_queue #(
        .DEPTH(DEPTH), .ENQ_N(ENQ_N), .DEQ_N(DEQ_N),
        .ENTRY_W(EWID), .AF_THRESH(AF)
    ) dut (
        .clk(clk), .rst(rst), .enq_count(enq_count), .enq_data(enq_data),
        .enq_ready(enq_ready), .deq_data(deq_data), .deq_avail(deq_avail),
        .deq_count(deq_count), .flush(flush), .occupancy(occupancy),
        .empty(empty), .full(full), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (enq_count <= 3'(ENQ_N)) else $error("[TB] illegal enq_count %0d", enq_count);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output against what the model queue says should be visible.
    task automatic checkModel();
        int sz;
        int avail;
        sz    = modelQ.size();
        avail = (sz < DEQ_N) ? sz : DEQ_N;
        checkOutput("occupancy",   32'(occupancy),   32'(sz));
        checkOutput("empty",       32'(empty),       32'(sz == 0));
        checkOutput("full",        32'(full),        32'(sz == DEPTH));
        checkOutput("almost_full", 32'(almost_full), 32'(sz >= AF));
        checkOutput("enq_ready",   32'(enq_ready),   32'((DEPTH - sz) >= ENQ_N));
        checkOutput("deq_avail",   32'(deq_avail),   32'(avail));
        for (int i = 0; i < DEQ_N; i++) begin
            checkOutput($sformatf("deq_lane%0d", i), deq_data[i*EWID +: EWID],
                        (i < sz) ? modelQ[i] : 32'h0);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, then check.
    task automatic applyStimulus(input int ec, input logic [ENQ_N*EWID-1:0] data,
                                 input int dc, input bit fl, input bit rs);
        int sz;
        int pop;
        bit ready;
        enq_count = 3'(ec);
        enq_data  = data;
        deq_count = 2'(dc);
        flush     = fl;
        rst       = rs;
        sz    = modelQ.size();
        ready = (DEPTH - sz) >= ENQ_N;
        if (rs || fl) begin
            modelQ.delete();
        end else begin
            pop = (dc < sz) ? dc : sz;
            if (pop > DEQ_N) pop = DEQ_N;
            for (int i = 0; i < pop; i++) void'(modelQ.pop_front());
            if (ready && ec > 0) begin
                for (int i = 0; i < ec; i++) modelQ.push_back(data[i*EWID +: EWID]);
            end
        end
        @(posedge clk);
        #1;
        enq_count = '0;
        deq_count = '0;
        flush     = 1'b0;
        rst       = 1'b0;
        checkModel();
    endtask

    function automatic logic [ENQ_N*EWID-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    localparam logic [31:0] VA = 32'hA000_000A, VB = 32'hB000_000B, VC = 32'hC000_000C;
    localparam logic [31:0] VD = 32'hD000_000D, VE = 32'hE000_000E, VF = 32'hF000_000F;
    localparam logic [31:0] VG = 32'h1000_0010, VH = 32'h2000_0020, VI = 32'h3000_0030;
    localparam logic [31:0] VJ = 32'h4000_0040, VK = 32'h5000_0050, VL = 32'h6000_0060;
    localparam logic [31:0] VM = 32'h7000_0070, VX = 32'hDEAD_BEEF;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1; flush = 1'b0; enq_count = '0; deq_count = '0; enq_data = '0;

        applyStimulus(0, '0, 0, 0, 1);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_empty",     32'(empty),     32'd1);
        checkOutput("rst_enq_ready", 32'(enq_ready), 32'd1);
        checkOutput("rst_deq_data",  deq_data[31:0] | deq_data[63:32], 32'd0);

        // Basic enqueue and pop
        applyStimulus(3, pack4(VA, VB, VC, 0), 0, 0, 0);
        checkOutput("tp1_occ",   32'(occupancy), 32'd3);
        checkOutput("tp1_avail", 32'(deq_avail), 32'd2);
        checkOutput("tp1_lane0", deq_data[31:0],  VA);
        checkOutput("tp1_lane1", deq_data[63:32], VB);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp1_pop_occ",   32'(occupancy), 32'd1);
        checkOutput("tp1_pop_lane0", deq_data[31:0],  VC);
        checkOutput("tp1_pop_lane1", deq_data[63:32], 32'd0);

        // Fill and reject
        applyStimulus(0, '0, 0, 1, 0);
        applyStimulus(4, pack4(VA, VB, VC, VD), 0, 0, 0);
        applyStimulus(4, pack4(VE, VF, VG, VH), 0, 0, 0);
        checkOutput("tp2_full",  32'(full),      32'd1);
        checkOutput("tp2_af",    32'(almost_full), 32'd1);
        checkOutput("tp2_ready", 32'(enq_ready), 32'd0);
        applyStimulus(1, pack4(VX, 0, 0, 0), 0, 0, 0);
        checkOutput("tp2_rej_occ", 32'(occupancy), 32'd8);

        // Wrap-around: drain to 4, refill past the end of storage
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp3_ready_at6", 32'(enq_ready), 32'd0);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp3_ready_at4", 32'(enq_ready), 32'd1);
        checkOutput("tp3_lane0",     deq_data[31:0], VE);
        applyStimulus(4, pack4(VI, VJ, VK, VL), 0, 0, 0);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp3_lane0_g", deq_data[31:0], VG);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp3_lane0_i", deq_data[31:0], VI);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp3_lane0_k", deq_data[31:0],  VK);
        checkOutput("tp3_lane1_l", deq_data[63:32], VL);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp3_empty", 32'(empty), 32'd1);

        // Concurrent enqueue and pop, then clamped over-pop
        applyStimulus(3, pack4(VA, VB, VC, 0), 0, 0, 0);
        applyStimulus(4, pack4(VD, VE, VF, VG), 2, 0, 0);
        checkOutput("tp4_occ5", 32'(occupancy), 32'd5);
        applyStimulus(0, '0, 2, 0, 0);
        applyStimulus(0, '0, 2, 0, 0);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp4_overpop_occ", 32'(occupancy), 32'd0);
        applyStimulus(0, '0, 2, 0, 0);
        checkOutput("tp4_underflow", 32'(occupancy), 32'd0);

        // Flush priority over enqueue and pop
        applyStimulus(4, pack4(VA, VB, VC, VD), 0, 0, 0);
        applyStimulus(1, pack4(VE, 0, 0, 0), 0, 0, 0);
        checkOutput("tp5_occ5", 32'(occupancy), 32'd5);
        applyStimulus(4, pack4(VF, VG, VH, VI), 2, 1, 0);
        checkOutput("tp5_flush_empty", 32'(empty), 32'd1);
        checkOutput("tp5_flush_data",  deq_data[31:0] | deq_data[63:32], 32'd0);
        applyStimulus(1, pack4(VM, 0, 0, 0), 0, 0, 0);
        checkOutput("tp5_lane0_m", deq_data[31:0], VM);

        // Reset mid-operation overrides a simultaneous flush
        applyStimulus(2, pack4(VA, VB, 0, 0), 0, 0, 0);
        applyStimulus(4, pack4(VC, VD, VE, VF), 0, 0, 0);
        checkOutput("tp6_occ7", 32'(occupancy), 32'd7);
        applyStimulus(4, pack4(VG, VH, VI, VJ), 1, 1, 1);
        checkOutput("tp6_occ",   32'(occupancy),   32'd0);
        checkOutput("tp6_empty", 32'(empty),       32'd1);
        checkOutput("tp6_full",  32'(full),        32'd0);
        checkOutput("tp6_af",    32'(almost_full), 32'd0);
        checkOutput("tp6_avail", 32'(deq_avail),   32'd0);
        checkOutput("tp6_ready", 32'(enq_ready),   32'd1);
        checkOutput("tp6_data",  deq_data[31:0] | deq_data[63:32], 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [ENQ_N*EWID-1:0] d;
            for (int l = 0; l < ENQ_N; l++) d[l*EWID +: EWID] = $urandom;
            applyStimulus($urandom_range(0, ENQ_N), d, $urandom_range(0, 3),
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/micro_op_queue.md
# micro_op_queue

Parametrised micro-op queue between the fetch/pre-decode stage and the decode stage of the x86-64 pipeline. It accepts up to `ENQ_N` micro-ops per cycle from fetch, where one x86 instruction expands into several micro-ops. It presents up to `DEQ_N` oldest micro-ops per cycle to decode, which may retire any number of them in order. It generalises the single-head decode queue with these additions:

- multi-issue dequeue
- configurable depth and entry width
- an occupancy count and an almost-full watermark for fetch throttling
- flush on branch mispredict

## Interface

Parameters:
- `DEPTH`, 16: number of entries; must be a power of two and ≥ `ENQ_N`.
- `ENQ_N`, 4: maximum micro-ops written per cycle.
- `DEQ_N`, 2: maximum micro-ops presented and popped per cycle.
- `ENTRY_W`, 128: packed micro-op width (opcode, reg addrs d/s/t, immediate, bit mode, pc; packed by the caller).
- `AF_THRESH`, 12: `almost_full` asserts when occupancy ≥ `AF_THRESH`.

Derived widths:
- `PW` = clog2(`DEPTH`)
- `CW` = `PW`+1

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enq_count`  in  clog2(`ENQ_N`+1)  number of valid lanes in `enq_data`, lanes 0..`enq_count`-1; lane 0 is the oldest.
- `enq_data`  in  `ENQ_N`*`ENTRY_W`  lane i occupies bits [i*`ENTRY_W` +: `ENTRY_W`].
- `enq_ready`  out  1  high when free slots ≥ `ENQ_N`.
- `deq_data`  out  `DEQ_N`*`ENTRY_W`  lane i holds the i-th oldest entry.
- `deq_avail`  out  clog2(`DEQ_N`+1)  min(occupancy, `DEQ_N`).
- `deq_count`  in  clog2(`DEQ_N`+1)  number of entries popped this cycle.
- `flush`  in  1  discard all contents.
- `occupancy`  out  `CW`  current entry count.
- `empty`  out  1  occupancy == 0.
- `full`  out  1  occupancy == `DEPTH`.
- `almost_full`  out  1  occupancy ≥ `AF_THRESH`.

## Operation

State:
- storage array `DEPTH`×`ENTRY_W`
- `head` and `tail` pointers, `PW` bits each, wrapping naturally modulo `DEPTH`
- `occupancy` counter, `CW` bits

Enqueue:
- Accepted iff `enq_ready` && `enq_count` > 0 && !`flush`.
- Acceptance is all-or-nothing: all `enq_count` lanes are written to `tail`..`tail`+`enq_count`-1 (mod `DEPTH`), and `tail` advances by `enq_count`.
- `enq_count` > `ENQ_N` is illegal; the bench asserts it never occurs.

Dequeue:
- Effective pop = min(`deq_count`, `deq_avail`), so over-pop is clamped silently.
- `head` advances by the effective pop when !`flush`.

Occupancy:
- next = occupancy + accepted enq − effective pop.
- Simultaneous enqueue and dequeue are both applied.

`enq_ready`:
- Computed from the current occupancy only (`DEPTH` − occupancy ≥ `ENQ_N`).
- A same-cycle pop does not count towards readiness; this is a deliberate timing cut.

`deq_data`:
- Lane i = storage[`head`+i mod `DEPTH`] for i < `deq_avail`.
- Lanes ≥ `deq_avail` are driven to zero.

Flush:
- `flush` has priority over enqueue and dequeue.
- Next cycle: `head` = `tail` = 0, occupancy = 0.
- Storage contents are not cleared; they are unobservable because of the zero mask.

Reset:
- Identical to flush, and has priority over it.
- Reset values: `occupancy` 0, `empty` 1, `full` 0, `almost_full` 0, `deq_avail` 0, `deq_data` 0, `enq_ready` 1.

FIFO order is strictly preserved across wrap-around.

## Timing

- Enqueue to visibility: 1 cycle. An entry written at edge N appears on `deq_data` and is counted in `deq_avail` after edge N. There is no bypass from `enq_data` to `deq_data`.
- All status outputs (`occupancy`, `empty`, `full`, `almost_full`, `enq_ready`, `deq_avail`) are pure functions of registered state and change only after a clock edge.
- `deq_data` is a combinational read of registered storage through a `head`-indexed mux.
- Reset or flush asserted mid-burst: the queue is empty in the following cycle, and no entry accepted in the flush or reset cycle survives.
- A pop of 0 with an enqueue at full: the enqueue is rejected (`enq_ready`=0) and state is unchanged.
- A pop at empty: no effect, and occupancy does not underflow.

## Test plan

All scenarios use `DEPTH`=8, `ENQ_N`=4, `DEQ_N`=2, `AF_THRESH`=6.

1. **Basic enqueue:** after reset, enqueue 3 entries A,B,C → next cycle `occupancy`=3, `deq_avail`=2, lane0=A, lane1=B. Then pop 2 → `occupancy`=1, lane0=C, lane1=0.
2. **Fill and reject:** enqueue 4 (A–D), then 4 (E–H) → `occupancy`=8, `full`=1, `almost_full`=1, `enq_ready`=0. Then `enq_count`=1 with data X → state unchanged, and X never appears.
3. **Wrap-around:**
   - From full, pop 2 per cycle for 2 cycles. `enq_ready` must be 0 at `occupancy` 6 and 1 at `occupancy` 4.
   - Then enqueue I–L, wrapping `tail` → dequeue order E,F,G,H,I,J,K,L.
4. **Concurrent enqueue and pop:** at `occupancy` 3, enqueue 4 and `deq_count`=2 in the same cycle → `occupancy`=5. Also `deq_count`=2 with `deq_avail`=1 → pops exactly 1.
5. **Flush priority:** at `occupancy` 5, assert `flush` together with an enqueue of 4 and a pop of 2 → next cycle `occupancy`=0, `empty`=1, `deq_data`=0. A subsequent enqueue of M → lane0=M.
6. **Reset mid-operation:** assert `rst` at `occupancy` 7 with an enqueue pending → all outputs equal their reset values next cycle, and `rst` overrides a simultaneous `flush`.
